expr_sweep_ctrl: RTL and testbench

Sequencer that drives an exhaustive input sweep across two combinational boolean-expression blocks and compares their outputs. It applies every N_IN-bit input vector in ascending order and waits a programmable settle time. It then samples both expression outputs, builds their truth tables, and reports equivalence, the mismatch count and the first mismatching vector. It replaces the display-driven truth-table loops with a synthesizable, self-checking equivalence controller placed in front of the gate-level expression modules.

---
 rtl/expr_sweep_pkg.sv | 13 +
 rtl/settle_timer.sv | 30 +++
 rtl/expr_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_expr_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/expr_sweep_pkg.sv
// Shared types and default constants for the expression sweep controller.
package expr_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE
  } sweep_state_t;

  localparam int unsigned EXPR_N_IN   = 4;
  localparam int unsigned EXPR_SETTLE = 1;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the settle window between driving a vector and sampling it.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE - 1);

  logic [CntW-1:0] r_cnt;

  // Loading SETTLE-1 and expiring at zero gives SETTLE cycles in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/expr_sweep_ctrl.sv
// Exhaustive input sweep over two boolean expressions; captures both truth tables
// and reports mismatch count, first mismatching vector and equivalence.
module expr_sweep_ctrl
  import expr_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = EXPR_N_IN,
  parameter int unsigned SETTLE = EXPR_SETTLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_a,
  input  logic                   f_b,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_a,
  output logic [(2**N_IN)-1:0]   table_b,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_mismatch,
  output logic                   equal
);

  localparam int unsigned NVec = 2 ** N_IN;
  localparam logic [N_IN-1:0] LastIdx = '1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("expr_sweep_ctrl: SETTLE must be >= 1");
  end

  sweep_state_t    r_state, w_state_next;
  logic [N_IN-1:0] r_idx, w_idx_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic [NVec-1:0] r_table_a, w_table_a_next;
  logic [NVec-1:0] r_table_b, w_table_b_next;
  logic [N_IN:0]   r_mm_cnt, w_mm_cnt_next;
  logic [N_IN-1:0] r_first, w_first_next;
  logic            r_seen, w_seen_next;
  logic            r_equal, w_equal_next;
  logic            w_load;
  logic            w_expired;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_en      (r_state == WAIT),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_table_a_next = r_table_a;
    w_table_b_next = r_table_b;
    w_mm_cnt_next  = r_mm_cnt;
    w_first_next   = r_first;
    w_seen_next    = r_seen;
    w_equal_next   = r_equal;
    w_load         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next   = WAIT;
          w_idx_next     = '0;
          w_busy_next    = 1'b1;
          w_table_a_next = '0;
          w_table_b_next = '0;
          w_mm_cnt_next  = '0;
          w_first_next   = '0;
          w_seen_next    = 1'b0;
          w_equal_next   = 1'b0;
          w_load         = 1'b1;
        end
      end
      WAIT: begin
        if (abort) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
        end else if (w_expired) begin
          w_state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        // Abort wins over the capture, so the current table bit stays unwritten.
        if (abort) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
        end else begin
          w_table_a_next[r_idx] = f_a;
          w_table_b_next[r_idx] = f_b;
          if (f_a != f_b) begin
            w_mm_cnt_next = r_mm_cnt + 1'b1;
            if (!r_seen) begin
              w_first_next = r_idx;
              w_seen_next  = 1'b1;
            end
          end
          if (r_idx == LastIdx) begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_equal_next = (w_mm_cnt_next == '0);
          end else begin
            w_state_next = WAIT;
            w_idx_next   = r_idx + 1'b1;
            w_load       = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_table_a <= '0;
      r_table_b <= '0;
      r_mm_cnt  <= '0;
      r_first   <= '0;
      r_seen    <= 1'b0;
      r_equal   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_table_a <= w_table_a_next;
      r_table_b <= w_table_b_next;
      r_mm_cnt  <= w_mm_cnt_next;
      r_first   <= w_first_next;
      r_seen    <= w_seen_next;
      r_equal   <= w_equal_next;
    end
  end

  assign vec_out        = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign table_a        = r_table_a;
  assign table_b        = r_table_b;
  assign mismatch_cnt   = r_mm_cnt;
  assign first_mismatch = r_first;
  assign equal          = r_equal;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// Scoreboard bench: two controller instances (SETTLE=1 and SETTLE=3) driving small expressions.
module tb_expr_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic f_a1, f_b1, f_a3, f_b3;
  logic [3:0]  vec1, vec3, first1, first3;
  logic        busy1, busy3, done1, done3, equal1, equal3;
  logic [15:0] ta1, tb1, ta3, tb3;
  logic [4:0]  cnt1, cnt3;

  int mode1 = 0;
  int mode3 = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] tab_a;
    logic [15:0] tab_b;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        eq;
    int          k;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: distinct A/B, mode 1: identical, mode 2: A=1, B=0
  function automatic logic fa_sel(int mode, logic [3:0] v);
    logic a, b, d;
    a = v[3]; b = v[2]; d = v[0];
    if (mode == 2) return 1'b1;
    return (~a & d) | (a & ~b);
  endfunction

  function automatic logic fb_sel(int mode, logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    case (mode)
      0:       return (~a & ~c & d) | (a & ~b) | (~b & d);
      1:       return (~a & d) | (a & ~b);
      default: return 1'b0;
    endcase
  endfunction

  assign f_a1 = fa_sel(mode1, vec1);
  assign f_b1 = fb_sel(mode1, vec1);
  assign f_a3 = fa_sel(mode3, vec3);
  assign f_b3 = fb_sel(mode3, vec3);

  expr_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_a(f_a1), .f_b(f_b1),
    .vec_out(vec1), .busy(busy1), .done(done1), .table_a(ta1), .table_b(tb1),
    .mismatch_cnt(cnt1), .first_mismatch(first1), .equal(equal1)
  );

  expr_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f_a(f_a3), .f_b(f_b3),
    .vec_out(vec3), .busy(busy3), .done(done3), .table_a(ta3), .table_b(tb3),
    .mismatch_cnt(cnt3), .first_mismatch(first3), .equal(equal3)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_res(string tag, exp_t e, logic [15:0] ta, logic [15:0] tb,
                           logic [4:0] cnt, logic [3:0] first, logic eq, logic bsy);
    chk({tag, " done latency"}, cyc - e.k, e.lat);
    chk({tag, " table_a"}, {16'h0, ta}, {16'h0, e.tab_a});
    chk({tag, " table_b"}, {16'h0, tb}, {16'h0, e.tab_b});
    chk({tag, " mismatch_cnt"}, {27'h0, cnt}, {27'h0, e.cnt});
    chk({tag, " first_mismatch"}, {28'h0, first}, {28'h0, e.first});
    chk({tag, " equal"}, {31'h0, eq}, {31'h0, e.eq});
    chk({tag, " busy at done"}, {31'h0, bsy}, 32'h0);
  endtask

  // Monitor: pops an expectation whenever a DUT presents done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("dut1 done with no pending sweep", {31'h0, done1}, 32'h0);
      else begin
        e = q1.pop_front();
        check_res("dut1", e, ta1, tb1, cnt1, first1, equal1, busy1);
      end
    end
    if (rst_n && done3) begin
      if (q3.size() == 0) chk("dut3 done with no pending sweep", {31'h0, done3}, 32'h0);
      else begin
        e = q3.pop_front();
        check_res("dut3", e, ta3, tb3, cnt3, first3, equal3, busy3);
      end
    end
  end

  task automatic sweep1(int mode, logic [15:0] ta, logic [15:0] tb, logic [4:0] cnt,
                        logic [3:0] first, logic eq);
    exp_t e;
    int n;
    mode1 = mode;
    @(negedge clk);
    start1 = 1'b1;
    e.tab_a = ta; e.tab_b = tb; e.cnt = cnt; e.first = first; e.eq = eq;
    e.k = cyc + 1; e.lat = 32;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1 busy after start", {31'h0, busy1}, 32'h1);
    n = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dut1 sweep finished in bound", {31'h0, busy1}, 32'h0);
    @(negedge clk);
    chk("dut1 done one cycle", {31'h0, done1}, 32'h0);
    chk("dut1 table_a holds", {16'h0, ta1}, {16'h0, ta});
  endtask

  initial begin
    exp_t e;
    int n;
    int k;

    repeat (2) @(negedge clk);
    chk("reset busy", {31'h0, busy1}, 32'h0);
    chk("reset done", {31'h0, done1}, 32'h0);
    chk("reset vec_out", {28'h0, vec1}, 32'h0);
    chk("reset tables", {ta1, tb1}, 32'h0);
    chk("reset cnt/first/equal", {23'h0, cnt1, first1, equal1}, 32'h0);
    chk("reset dut3 busy/vec", {27'h0, busy3, vec3}, 32'h0);
    rst_n = 1'b1;

    sweep1(0, 16'h0FAA, 16'h0F2A, 5'd1, 4'd7, 1'b0);
    sweep1(1, 16'h0FAA, 16'h0FAA, 5'd0, 4'd0, 1'b1);
    sweep1(2, 16'hFFFF, 16'h0000, 5'd16, 4'd0, 1'b0);

    // SETTLE=3: vectors step every 4 cycles; a start mid-sweep is ignored.
    mode3 = 0;
    @(negedge clk);
    start3 = 1'b1;
    e.tab_a = 16'h0FAA; e.tab_b = 16'h0F2A; e.cnt = 5'd1; e.first = 4'd7; e.eq = 1'b0;
    e.k = cyc + 1; e.lat = 64;
    q3.push_back(e);
    @(negedge clk);
    start3 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk("dut3 vec_out first cycle", {28'h0, vec3}, j);
      repeat (3) @(negedge clk);
      chk("dut3 vec_out last cycle", {28'h0, vec3}, j);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("dut3 busy after stray start", {31'h0, busy3}, 32'h1);
    n = 0;
    while (busy3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("dut3 sweep finished in bound", {31'h0, busy3}, 32'h0);
    @(negedge clk);
    chk("dut3 done one cycle", {31'h0, done3}, 32'h0);

    // Abort landing on the SAMPLE edge of vector 5.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    while (cyc < k + 11) @(negedge clk);
    chk("abort setup vec_out", {28'h0, vec1}, 32'd5);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort busy", {31'h0, busy1}, 32'h0);
    chk("abort done", {31'h0, done1}, 32'h0);
    chk("abort vec_out holds", {28'h0, vec1}, 32'd5);
    chk("abort table_a partial", {16'h0, ta1}, 32'h000A);
    chk("abort table_b partial", {16'h0, tb1}, 32'h000A);
    chk("abort cnt/equal", {26'h0, cnt1, equal1}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort stays idle", {30'h0, busy1, done1}, 32'h0);

    // Asynchronous reset mid-sweep at vector 9.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (vec1 != 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reset setup vec_out", {28'h0, vec1}, 32'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("mid reset busy/done/equal", {29'h0, busy1, done1, equal1}, 32'h0);
    chk("mid reset vec_out", {28'h0, vec1}, 32'h0);
    chk("mid reset tables", {ta1, tb1}, 32'h0);
    chk("mid reset cnt/first", {23'h0, cnt1, first1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep1(1, 16'h0FAA, 16'h0FAA, 5'd0, 4'd0, 1'b1);

    repeat (2) @(negedge clk);
    chk("dut1 pending expectations", q1.size(), 32'h0);
    chk("dut3 pending expectations", q3.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
